core_controller: RTL and testbench
==================================

# core_controller

Multi-cycle instruction sequencer for the TiniSOC core. It sits directly upstream of the register file and drives its `enable_reg_fetch` and `enable_reg_write` strobes. It fetches instructions through a req/ack handshake, holds the program counter, and steps each instruction through fetch, decode, execute, memory and writeback. It also counts retired instructions.

## Interface
- `PcSize`, 32: program counter and instruction-address width.
- `DataSize`, 32: instruction width.
- `ResetPc`, 0: PC value after reset.
- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; asserting it forces every register to its reset value at once.
- `enable_run` in 1: permits instruction issue; sampled only in IDLE and at instruction boundaries.
- `im_req` out 1: instruction-memory request.
- `im_addr` out PcSize: equals `pc`.
- `im_ack` in 1: instruction-memory acknowledge; `im_rdata` is valid in the same cycle.
- `im_rdata` in DataSize: fetched instruction.
- `instruction` out DataSize: latched instruction register; feeds the decoder.
- `op_class` in 2: decoder output from `instruction`. 0 = ALU, 1 = LOAD, 2 = STORE, 3 = BRANCH.
- `branch_taken` in 1, `branch_target` in PcSize: from the execute unit; valid in EXECUTE.
- `enable_reg_fetch` out 1: register-file operand-fetch strobe.
- `enable_execute` out 1: ALU/branch-evaluate strobe.
- `dm_req` out 1, `dm_we` out 1, `dm_ack` in 1: data-memory handshake.
- `enable_reg_write` out 1: register-file write strobe.
- `pc` out PcSize: current program counter.
- `retired` out 32: retired-instruction count.

## Operation
- Moore FSM with states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK. All strobes decode combinationally from the state register.
- **IDLE**: all strobes 0. Goes to FETCH when `enable_run`=1.
- **FETCH**:
  - `im_req`=1 and is held until `im_ack`.
  - On `im_ack`: `instruction` <= `im_rdata`, go to DECODE.
  - Without ack: stay; no timeout.
- **DECODE**: `enable_reg_fetch`=1 for exactly one cycle, then go to EXECUTE.
- **EXECUTE**: `enable_execute`=1 for one cycle. Next state depends on `op_class`:
  - ALU: go to WRITEBACK.
  - LOAD or STORE: go to MEMORY.
  - BRANCH: `pc` <= `branch_taken` ? `branch_target` : `pc`+4. The instruction retires.
- **MEMORY**:
  - `dm_req`=1, `dm_we`=1 for STORE, 0 for LOAD; held until `dm_ack`.
  - On ack, LOAD goes to WRITEBACK.
  - On ack, STORE sets `pc` <= `pc`+4 and retires.
- **WRITEBACK**: `enable_reg_write`=1 for one cycle; `pc` <= `pc`+4; the instruction retires.
- **Retire step**: `retired` increments by 1. Next state is FETCH if `enable_run`=1, else IDLE.
- `pc`+4 wraps modulo 2^PcSize.
- `branch_target` is loaded unmodified; alignment is not checked.
- `retired` wraps from 0xFFFFFFFF to 0.
- `im_ack` outside FETCH and `dm_ack` outside MEMORY are ignored.
- Deasserting `enable_run` mid-instruction does not abort the instruction; it completes and the FSM then enters IDLE.
- `op_class` is only sampled in EXECUTE and MEMORY.

## Timing
- Reset values:
  - state IDLE; `pc` = ResetPc; `instruction` = 0; `retired` = 0.
  - `im_req`, `dm_req`, `dm_we`, `enable_reg_fetch`, `enable_execute`, `enable_reg_write` all 0.
- Latency with single-cycle acks, from entering FETCH to the next FETCH:
  - ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each cycle of wait on `im_ack` or `dm_ack` adds one cycle.
- The register file captures operands at the rising edge that ends DECODE. Its write occurs at the rising edge that ends WRITEBACK. The two strobes are never high together.
- `pc` and `retired` update on the same edge that leaves the retiring state, and `im_addr` shows the new `pc` in the next FETCH.
- Reset mid-handshake drops `im_req`/`dm_req` immediately (asynchronously), and no retire is counted.

## Structure
- A shared package holds the state encoding localparams, the `op_class` constants (OP_ALU/OP_LOAD/OP_STORE/OP_BRANCH), and the PC increment constant 4.
- Single module; no sub-module is warranted. The PC/retire update is a small always block inside the module.

## Test plan
- **Reset and idle.** Apply reset with `enable_run`=0. Expect `pc`=ResetPc, all strobes 0 and `retired`=0. The FSM stays in IDLE for 10 cycles.
- **ALU instruction.** Set `enable_run`=1, immediate `im_ack`, `im_rdata`=0x00000001, `op_class`=ALU. Expect `enable_reg_fetch` high in cycle 2, `enable_reg_write` high in cycle 4, then `pc`=4 and `retired`=1.
- **Handshake stalls.** Run a LOAD with `im_ack` delayed 3 cycles and `dm_ack` delayed 2 cycles. Expect `im_req` and `dm_req` to stay high throughout the wait, the instruction to complete in 10 cycles, and `pc`=4.
- **Branches.** A taken branch with `branch_target`=0x100 gives `pc`=0x100 after 3 cycles with no `enable_reg_write`. A not-taken branch gives `pc`=`pc`+4.
- **Boundary conditions.**
  - `pc`=0xFFFFFFFC plus an ALU instruction: `pc` wraps to 0.
  - `retired` preset near 0xFFFFFFFF: it wraps to 0.
  - Deassert `enable_run` during EXECUTE: the instruction completes, then the FSM enters IDLE.
- **Reset mid-MEMORY.** Assert reset with `dm_req` high. Expect `dm_req` to drop immediately, `pc`=ResetPc and `retired` unchanged from 0.

Source files
------------

// File: rtl/core_controller_pkg.sv
// Shared definitions for the core_controller instruction sequencer:
// FSM state encoding, decoder op-class codes and the sequential PC step.
package core_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  localparam logic [1:0] OP_ALU    = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_STORE  = 2'd2;
  localparam logic [1:0] OP_BRANCH = 2'd3;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/core_controller_if.sv
// Bundle of the sequencer's handshake, strobe and status signals.
// master = the controller, slave = memories / decoder / execute unit / register file.
interface core_controller_if #(
  parameter int PcSize   = 32,
  parameter int DataSize = 32
);
  logic                enable_run;
  logic                im_req;
  logic [PcSize-1:0]   im_addr;
  logic                im_ack;
  logic [DataSize-1:0] im_rdata;
  logic [DataSize-1:0] instruction;
  logic [1:0]          op_class;
  logic                branch_taken;
  logic [PcSize-1:0]   branch_target;
  logic                enable_reg_fetch;
  logic                enable_execute;
  logic                dm_req;
  logic                dm_we;
  logic                dm_ack;
  logic                enable_reg_write;
  logic [PcSize-1:0]   pc;
  logic [31:0]         retired;

  modport master (
    input  enable_run, im_ack, im_rdata, op_class, branch_taken, branch_target, dm_ack,
    output im_req, im_addr, instruction, enable_reg_fetch, enable_execute,
           dm_req, dm_we, enable_reg_write, pc, retired
  );

  modport slave (
    output enable_run, im_ack, im_rdata, op_class, branch_taken, branch_target, dm_ack,
    input  im_req, im_addr, instruction, enable_reg_fetch, enable_execute,
           dm_req, dm_we, enable_reg_write, pc, retired
  );
endinterface

// File: rtl/core_controller.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback
// Moore FSM with PC, instruction register and retired-instruction counter.
module core_controller
  import core_controller_pkg::*;
#(
  parameter int                PcSize   = 32,
  parameter int                DataSize = 32,
  parameter logic [PcSize-1:0] ResetPc  = '0
) (
  input  logic clock,
  input  logic reset,
  core_controller_if.master bus
);

  state_t              state_q, state_d;
  logic [PcSize-1:0]   pc_q, pc_d;
  logic [DataSize-1:0] instr_q, instr_d;
  logic [31:0]         retired_q, retired_d;
  logic                retire;
  logic [PcSize-1:0]   pc_plus4;

  logic im_req, dm_req, dm_we, en_fetch, en_exec, en_write;

  assign pc_plus4 = pc_q + PcSize'(PC_INC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every retiring path funnels through `retire` so the run/idle decision lives in one place.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE:   if (bus.enable_run) state_d = ST_FETCH;
      ST_FETCH:  if (bus.im_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        case (bus.op_class)
          OP_ALU:            state_d = ST_WRITEBACK;
          OP_LOAD, OP_STORE: state_d = ST_MEMORY;
          default:           retire  = 1'b1;
        endcase
      end
      ST_MEMORY: begin
        if (bus.dm_ack) begin
          if (bus.op_class == OP_STORE) retire  = 1'b1;
          else                          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: retire = 1'b1;
      default:      state_d = ST_IDLE;
    endcase
    if (retire) state_d = bus.enable_run ? ST_FETCH : ST_IDLE;
  end

  always_comb begin
    im_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    en_fetch = 1'b0;
    en_exec  = 1'b0;
    en_write = 1'b0;
    case (state_q)
      ST_FETCH:     im_req   = 1'b1;
      ST_DECODE:    en_fetch = 1'b1;
      ST_EXECUTE:   en_exec  = 1'b1;
      ST_MEMORY: begin
        dm_req = 1'b1;
        dm_we  = (bus.op_class == OP_STORE);
      end
      ST_WRITEBACK: en_write = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    if (state_q == ST_FETCH && bus.im_ack) instr_d = bus.im_rdata;
    if (retire) begin
      retired_d = retired_q + 32'd1;
      // Only a branch retires from EXECUTE; every other retire is sequential.
      if (state_q == ST_EXECUTE && bus.branch_taken) pc_d = bus.branch_target;
      else                                           pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= ResetPc;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign bus.im_req           = im_req;
  assign bus.im_addr          = pc_q;
  assign bus.instruction      = instr_q;
  assign bus.enable_reg_fetch = en_fetch;
  assign bus.enable_execute   = en_exec;
  assign bus.dm_req           = dm_req;
  assign bus.dm_we            = dm_we;
  assign bus.enable_reg_write = en_write;
  assign bus.pc               = pc_q;
  assign bus.retired          = retired_q;

endmodule

// File: tb/tb_core_controller.sv
// Directed self-checking bench for core_controller; strobe vectors are
// {im_req, enable_reg_fetch, enable_execute, dm_req, dm_we, enable_reg_write}.
module tb_core_controller;
  import core_controller_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  core_controller_if bus ();

  core_controller #(
    .PcSize  (32),
    .DataSize(32),
    .ResetPc (32'h0)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.im_req, bus.enable_reg_fetch, bus.enable_execute,
            bus.dm_req, bus.dm_we, bus.enable_reg_write};
  endfunction

  task automatic idle_inputs();
    bus.enable_run    = 1'b0;
    bus.im_ack        = 1'b0;
    bus.im_rdata      = '0;
    bus.op_class      = OP_ALU;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.dm_ack        = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want %b", strobes(), 6'b0); end
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    total++; if (bus.retired !== 32'h0) begin bad++; $display("FAIL reset_retired: got %h want %h", bus.retired, 32'h0); end
    total++; if (bus.instruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want %h", bus.instruction, 32'h0); end
    tick();
    rst_n = 1'b1;
    bus.im_ack = 1'b1;
    bus.dm_ack = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL idle_c%0d: got %b want %b", c, strobes(), 6'b0); end
    end
    idle_inputs();
    $display("test_reset: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_alu();
    bus.enable_run = 1'b1;
    bus.im_ack     = 1'b1;
    bus.im_rdata   = 32'h0000_0001;
    bus.op_class   = OP_ALU;
    tick();
    total++; if (strobes() !== 6'b100000) begin bad++; $display("FAIL alu_c1: got %b want %b", strobes(), 6'b100000); end
    total++; if (bus.im_addr !== 32'h0) begin bad++; $display("FAIL alu_addr: got %h want %h", bus.im_addr, 32'h0); end
    tick();
    total++; if (strobes() !== 6'b010000) begin bad++; $display("FAIL alu_c2: got %b want %b", strobes(), 6'b010000); end
    total++; if (bus.instruction !== 32'h1) begin bad++; $display("FAIL alu_instr: got %h want %h", bus.instruction, 32'h1); end
    tick();
    total++; if (strobes() !== 6'b001000) begin bad++; $display("FAIL alu_c3: got %b want %b", strobes(), 6'b001000); end
    tick();
    total++; if (strobes() !== 6'b000001) begin bad++; $display("FAIL alu_c4: got %b want %b", strobes(), 6'b000001); end
    bus.enable_run = 1'b0;
    tick();
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL alu_idle: got %b want %b", strobes(), 6'b0); end
    total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL alu_pc: got %h want %h", bus.pc, 32'h4); end
    total++; if (bus.retired !== 32'h1) begin bad++; $display("FAIL alu_retired: got %h want %h", bus.retired, 32'h1); end
    idle_inputs();
    $display("test_alu: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_stalls();
    logic [5:0] exp_tab [10];
    exp_tab = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b010000,
                6'b001000, 6'b000100, 6'b000100, 6'b000100, 6'b000001};
    apply_reset();
    bus.enable_run = 1'b1;
    bus.op_class   = OP_LOAD;
    bus.im_rdata   = 32'h0000_ABCD;
    tick();
    bus.enable_run = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      total++; if (strobes() !== exp_tab[c-1]) begin bad++; $display("FAIL stall_c%0d: got %b want %b", c, strobes(), exp_tab[c-1]); end
      bus.im_ack = (c == 4);
      bus.dm_ack = (c == 9);
      tick();
    end
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL stall_idle: got %b want %b", strobes(), 6'b0); end
    total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL stall_pc: got %h want %h", bus.pc, 32'h4); end
    total++; if (bus.instruction !== 32'hABCD) begin bad++; $display("FAIL stall_instr: got %h want %h", bus.instruction, 32'hABCD); end
    idle_inputs();
    $display("test_stalls: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_branch_and_wrap();
    apply_reset();
    bus.enable_run    = 1'b1;
    bus.im_ack        = 1'b1;
    bus.op_class      = OP_BRANCH;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    tick();
    tick();
    total++; if (strobes() !== 6'b010000) begin bad++; $display("FAIL br_c2: got %b want %b", strobes(), 6'b010000); end
    tick();
    total++; if (strobes() !== 6'b001000) begin bad++; $display("FAIL br_c3: got %b want %b", strobes(), 6'b001000); end
    tick();
    total++; if (strobes() !== 6'b100000) begin bad++; $display("FAIL br_refetch: got %b want %b", strobes(), 6'b100000); end
    total++; if (bus.im_addr !== 32'h100) begin bad++; $display("FAIL br_taken_pc: got %h want %h", bus.im_addr, 32'h100); end
    total++; if (bus.retired !== 32'h1) begin bad++; $display("FAIL br_retired: got %h want %h", bus.retired, 32'h1); end
    bus.branch_taken = 1'b0;
    tick();
    tick();
    tick();
    total++; if (bus.pc !== 32'h104) begin bad++; $display("FAIL br_not_taken_pc: got %h want %h", bus.pc, 32'h104); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    tick();
    tick();
    total++; if (bus.im_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL br_high_pc: got %h want %h", bus.im_addr, 32'hFFFF_FFFC); end
    bus.op_class = OP_ALU;
    tick();
    tick();
    tick();
    total++; if (strobes() !== 6'b000001) begin bad++; $display("FAIL wrap_wb: got %b want %b", strobes(), 6'b000001); end
    bus.enable_run = 1'b0;
    tick();
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'h0); end
    total++; if (bus.retired !== 32'h4) begin bad++; $display("FAIL wrap_retired: got %h want %h", bus.retired, 32'h4); end
    idle_inputs();
    $display("test_branch_and_wrap: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_retired_wrap();
    apply_reset();
    dut.retired_q  = 32'hFFFF_FFFE;
    bus.enable_run = 1'b1;
    bus.im_ack     = 1'b1;
    bus.op_class   = OP_ALU;
    for (int c = 1; c <= 4; c++) tick();
    tick();
    total++; if (bus.retired !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ret_max: got %h want %h", bus.retired, 32'hFFFF_FFFF); end
    tick();
    tick();
    tick();
    bus.enable_run = 1'b0;
    tick();
    total++; if (bus.retired !== 32'h0) begin bad++; $display("FAIL ret_wrap: got %h want %h", bus.retired, 32'h0); end
    total++; if (bus.pc !== 32'h8) begin bad++; $display("FAIL ret_pc: got %h want %h", bus.pc, 32'h8); end
    idle_inputs();
    $display("test_retired_wrap: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_run_deassert();
    apply_reset();
    bus.enable_run = 1'b1;
    bus.im_ack     = 1'b1;
    bus.dm_ack     = 1'b1;
    bus.op_class   = OP_STORE;
    tick();
    tick();
    tick();
    total++; if (strobes() !== 6'b001000) begin bad++; $display("FAIL st_exec: got %b want %b", strobes(), 6'b001000); end
    bus.enable_run = 1'b0;
    tick();
    total++; if (strobes() !== 6'b000110) begin bad++; $display("FAIL st_mem: got %b want %b", strobes(), 6'b000110); end
    tick();
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL st_idle: got %b want %b", strobes(), 6'b0); end
    total++; if (bus.pc !== 32'h4) begin bad++; $display("FAIL st_pc: got %h want %h", bus.pc, 32'h4); end
    total++; if (bus.retired !== 32'h1) begin bad++; $display("FAIL st_retired: got %h want %h", bus.retired, 32'h1); end
    tick();
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL st_stay_idle: got %b want %b", strobes(), 6'b0); end
    idle_inputs();
    $display("test_run_deassert: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  task automatic test_reset_mid_memory();
    bus.enable_run = 1'b1;
    bus.im_ack     = 1'b1;
    bus.op_class   = OP_LOAD;
    tick();
    bus.enable_run = 1'b0;
    tick();
    tick();
    tick();
    total++; if (strobes() !== 6'b000100) begin bad++; $display("FAIL mr_mem: got %b want %b", strobes(), 6'b000100); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.dm_req !== 1'b0) begin bad++; $display("FAIL mr_dm_req: got %b want %b", bus.dm_req, 1'b0); end
    total++; if (bus.pc !== 32'h0) begin bad++; $display("FAIL mr_pc: got %h want %h", bus.pc, 32'h0); end
    total++; if (bus.retired !== 32'h0) begin bad++; $display("FAIL mr_retired: got %h want %h", bus.retired, 32'h0); end
    tick();
    rst_n      = 1'b1;
    bus.dm_ack = 1'b1;
    tick();
    total++; if (strobes() !== 6'b0) begin bad++; $display("FAIL mr_idle: got %b want %b", strobes(), 6'b0); end
    idle_inputs();
    $display("test_reset_mid_memory: pc=%h retired=%0d", bus.pc, bus.retired);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_stalls();
    test_branch_and_wrap();
    test_retired_wrap();
    test_run_deassert();
    test_reset_mid_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
